// File: rtl/wb_stage_pkg.sv
// Shared widths and helpers for the writeback stage and its long-latency queue.
package wb_stage_pkg;
  localparam int REG_ADDR_BUS = 5;
  localparam int DATA_BUS     = 32;
  localparam int ZERO_REG     = 0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_lq.sv
// Long-latency result queue: FIFO with per-entry valid bits, kill-by-rd and
// up to two pops per cycle; the two oldest entries are exposed as head0/head1.
module wb_lq
  import wb_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = REG_ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [ADDR_W-1:0]       i_push_rd,
  input  logic [DATA_W-1:0]       i_push_data,
  input  logic                    i_kill_en0,
  input  logic [ADDR_W-1:0]       i_kill_rd0,
  input  logic                    i_kill_en1,
  input  logic [ADDR_W-1:0]       i_kill_rd1,
  input  logic [1:0]              i_pop_n,
  output logic                    o_head0_vld,
  output logic [ADDR_W-1:0]       o_head0_rd,
  output logic [DATA_W-1:0]       o_head0_data,
  output logic                    o_head1_vld,
  output logic [ADDR_W-1:0]       o_head1_rd,
  output logic [DATA_W-1:0]       o_head1_data,
  output logic [cnt_w(DEPTH)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_rd_ptr1;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_slot;
      logic w_kill;
      assign w_slot = i_push && (r_wr_ptr == PTR_W'(gi));
      // A new push also retires any older entry for the same register.
      assign w_kill = (i_kill_en0 && (r_rd[gi] == i_kill_rd0)) ||
                      (i_kill_en1 && (r_rd[gi] == i_kill_rd1)) ||
                      (i_push && (r_rd[gi] == i_push_rd));

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_vld[gi] <= 1'b0;
        end else if (w_slot) begin
          r_vld[gi] <= 1'b1;
        end else if (w_kill) begin
          r_vld[gi] <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (w_slot) begin
          r_rd[gi]   <= i_push_rd;
          r_data[gi] <= i_push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
      r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop_n);
    end
  end

  assign w_rd_ptr1    = r_rd_ptr + PTR_W'(1);
  assign o_head0_vld  = r_vld[r_rd_ptr];
  assign o_head0_rd   = r_rd[r_rd_ptr];
  assign o_head0_data = r_data[r_rd_ptr];
  assign o_head1_vld  = r_vld[w_rd_ptr1];
  assign o_head1_rd   = r_rd[w_rd_ptr1];
  assign o_head1_data = r_data[w_rd_ptr1];
  assign o_count      = r_count;
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges pipe0/pipe1 results with queued long-latency results
// onto two registered RF write ports, dropping x0 writes and stale values.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int DATA_W   = DATA_BUS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p0_valid,
  input  logic [ADDR_W-1:0]          p0_rd,
  input  logic [DATA_W-1:0]          p0_data,
  input  logic                       p1_valid,
  input  logic [ADDR_W-1:0]          p1_rd,
  input  logic [DATA_W-1:0]          p1_data,
  input  logic                       lu_valid,
  input  logic [ADDR_W-1:0]          lu_rd,
  input  logic [DATA_W-1:0]          lu_data,
  output logic                       lu_ready,
  output logic                       we1,
  output logic [ADDR_W-1:0]          waddr1,
  output logic [DATA_W-1:0]          wdata1,
  output logic                       we2,
  output logic [ADDR_W-1:0]          waddr2,
  output logic [DATA_W-1:0]          wdata2,
  output logic [cnt_w(LQ_DEPTH)-1:0] lq_count
);
  localparam int CNT_W = cnt_w(LQ_DEPTH);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(ZERO_REG);

  logic              w_p0_acc, w_p1_acc, w_p0_win, w_push;
  logic              w_h0_vld, w_h1_vld, w_h0_live, w_h1_live, w_has0, w_has1;
  logic [ADDR_W-1:0] w_h0_rd, w_h1_rd;
  logic [DATA_W-1:0] w_h0_data, w_h1_data;
  logic [1:0]        w_pop_n;
  logic              w_we1, w_we2;
  logic [ADDR_W-1:0] w_waddr1, w_waddr2;
  logic [DATA_W-1:0] w_wdata1, w_wdata2;
  logic              r_we1, r_we2;
  logic [ADDR_W-1:0] r_waddr1, r_waddr2;
  logic [DATA_W-1:0] r_wdata1, r_wdata2;

  assign w_p0_acc = p0_valid && (p0_rd != X0);
  assign w_p1_acc = p1_valid && (p1_rd != X0);
  assign w_p0_win = w_p0_acc && !(w_p1_acc && (p1_rd == p0_rd));
  assign lu_ready = (lq_count < CNT_W'(LQ_DEPTH));
  assign w_push   = lu_valid && lu_ready && (lu_rd != X0) &&
                    !(w_p0_acc && (lu_rd == p0_rd)) &&
                    !(w_p1_acc && (lu_rd == p1_rd));

  // Heads overwritten by a younger pipe result this cycle are treated as dead.
  assign w_has0    = (lq_count != '0);
  assign w_has1    = (lq_count > CNT_W'(1));
  assign w_h0_live = w_h0_vld && !(w_p0_acc && (w_h0_rd == p0_rd)) &&
                     !(w_p1_acc && (w_h0_rd == p1_rd));
  assign w_h1_live = w_h1_vld && !(w_p0_acc && (w_h1_rd == p0_rd)) &&
                     !(w_p1_acc && (w_h1_rd == p1_rd));

  wb_lq #(.DEPTH(LQ_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lq (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (lu_rd),
    .i_push_data (lu_data),
    .i_kill_en0  (w_p0_acc),
    .i_kill_rd0  (p0_rd),
    .i_kill_en1  (w_p1_acc),
    .i_kill_rd1  (p1_rd),
    .i_pop_n     (w_pop_n),
    .o_head0_vld (w_h0_vld),
    .o_head0_rd  (w_h0_rd),
    .o_head0_data(w_h0_data),
    .o_head1_vld (w_h1_vld),
    .o_head1_rd  (w_h1_rd),
    .o_head1_data(w_h1_data),
    .o_count     (lq_count)
  );

  always_comb begin
    w_we1    = w_p0_win;
    w_waddr1 = p0_rd;
    w_wdata1 = p0_data;
    w_we2    = w_p1_acc;
    w_waddr2 = p1_rd;
    w_wdata2 = p1_data;
    w_pop_n  = 2'd0;
    if (w_has0) begin
      if (!w_h0_live) begin
        w_pop_n = 2'd1;
      end else if (!w_we1) begin
        w_we1 = 1'b1; w_waddr1 = w_h0_rd; w_wdata1 = w_h0_data; w_pop_n = 2'd1;
      end else if (!w_we2) begin
        w_we2 = 1'b1; w_waddr2 = w_h0_rd; w_wdata2 = w_h0_data; w_pop_n = 2'd1;
      end
    end
    // The second entry may only go once the first has left, keeping FIFO order.
    if ((w_pop_n == 2'd1) && w_has1) begin
      if (!w_h1_live) begin
        w_pop_n = 2'd2;
      end else if (!w_we1) begin
        w_we1 = 1'b1; w_waddr1 = w_h1_rd; w_wdata1 = w_h1_data; w_pop_n = 2'd2;
      end else if (!w_we2) begin
        w_we2 = 1'b1; w_waddr2 = w_h1_rd; w_wdata2 = w_h1_data; w_pop_n = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we1    <= 1'b0;
      r_we2    <= 1'b0;
      r_waddr1 <= '0;
      r_waddr2 <= '0;
      r_wdata1 <= '0;
      r_wdata2 <= '0;
    end else begin
      r_we1 <= w_we1;
      r_we2 <= w_we2;
      if (w_we1) begin
        r_waddr1 <= w_waddr1;
        r_wdata1 <= w_wdata1;
      end
      if (w_we2) begin
        r_waddr2 <= w_waddr2;
        r_wdata2 <= w_wdata2;
      end
    end
  end

  assign we1    = r_we1;
  assign waddr1 = r_waddr1;
  assign wdata1 = r_wdata1;
  assign we2    = r_we2;
  assign waddr2 = r_waddr2;
  assign wdata2 = r_wdata2;
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the dual-issue core, placed directly upstream of the register file's two write ports.
- Each cycle it collects up to two in-order results from the pipe0/pipe1 MEM/WB registers.
- It also accepts results from the long-latency unit (divider/load-miss) through a valid/ready handshake and holds them in a small queue.
- It arbitrates all results onto RF write ports 1/2 through registered outputs, suppresses x0 writes and resolves WAW conflicts.

Parameters:
- LQ_DEPTH, 2, long-latency result queue entries (power of 2, >=2).
- ADDR_W, 5, register address width (matches REG_ADDR_BUS).
- DATA_W, 32, data width (matches DATA_BUS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- p0_valid  in  1  pipe0 (older slot) result valid.
- p0_rd  in  ADDR_W  pipe0 destination.
- p0_data  in  DATA_W  pipe0 result.
- p1_valid  in  1  pipe1 (younger slot) result valid.
- p1_rd  in  ADDR_W  pipe1 destination.
- p1_data  in  DATA_W  pipe1 result.
- lu_valid  in  1  long-latency result offered.
- lu_rd  in  ADDR_W  its destination.
- lu_data  in  DATA_W  its result.
- lu_ready  out  1  queue can accept.
- we1  out  1  RF write enable, port 1.
- waddr1  out  ADDR_W  RF write address, port 1.
- wdata1  out  DATA_W  RF write data, port 1.
- we2  out  1  RF write enable, port 2.
- waddr2  out  ADDR_W  RF write address, port 2.
- wdata2  out  DATA_W  RF write data, port 2.
- lq_count  out  clog2(LQ_DEPTH)+1  occupied queue entries (for stall/debug).

Behaviour:
- Reset (rst=0 at an edge):
  - we1, we2, waddr*, wdata* and lq_count go to 0; all queue entries are invalid; lu_ready=1 in the cycle after reset.
  - A reset mid-operation discards queued results.
- Ordering contract: any pipe result is younger than every queued or same-cycle long-latency result.
- Latency:
  - Pipe results seen at edge t drive the RF outputs from t+1 (one registered stage).
  - An lu result accepted at edge t enters the queue at t; it can be written to the RF earliest from t+2.
- Pipe filtering:
  - An entry with valid=0 or rd=0 is dropped.
  - If p0 and p1 are both accepted with equal rd, p0 is dropped (the younger p1 wins).
- Kill: at each edge, every queue entry whose rd equals an accepted pipe rd has its valid bit cleared. An incoming lu result whose rd equals an accepted pipe rd is handshaken but not stored.
- Port allocation (combinational, then registered):
  - Surviving p0 takes port 1; surviving p1 takes port 2.
  - Free ports are given to live queue head entries in FIFO order, port 1 first, then port 2.
  - Two live queue entries never share an rd. If a queue entry matches the rd of another queue entry behind it, the older entry is killed on enqueue.
- Pop rules:
  - Dead (killed) entries at the head pop without using a port.
  - Total pops per cycle are at most 2, dead or written combined.
- Handshake:
  - lu_ready = (lq_count < LQ_DEPTH), based on registered state only; there is no combinational path from drain or from lu_valid.
  - Transfer occurs when lu_valid & lu_ready. lu_rd=0 is accepted and discarded.
- Simultaneous events:
  - Enqueue and pop in the same cycle are allowed.
  - When full with a pop in progress, lu_ready is still 0 (no bypass).
  - lq_count is updated as count + push − pops.
- Pointers wrap modulo LQ_DEPTH. Full/empty are derived from lq_count.
- Idle cycles deassert we1/we2; waddr/wdata keep their last values.

Decomposition:
- Shared package/header (def.vh): ADDR_W/DATA_W via REG_ADDR_BUS/DATA_BUS, ZERO_REG constant, clog2 helper macro.
- One sub-module: wb_lq, a LQ_DEPTH-entry FIFO with a per-entry valid bit, a kill-by-rd input and dual pop (push, kill_rd0/kill_rd1 with enables, pop_n[1:0], head0/head1 outputs).
- The arbitration and output registers live in wb_stage.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> we1=we2=0, lq_count=0, lu_ready=1.
- Dual pipe: p0(rd=3,0xAAAA), p1(rd=7,0xBBBB) at edge t -> at t+1 we1=1/waddr1=3/wdata1=0xAAAA and we2=1/waddr2=7/wdata2=0xBBBB.
- WAW and x0: p0(rd=5,0x1), p1(rd=5,0x2) -> only one write to rd5, value 0x2. p0(rd=0) -> no write.
- Queue drain:
  - Pipes idle; lu(rd=9,0x99) accepted at t -> write to port 1 at t+2.
  - Two lu results on back-to-back edges with both pipes busy -> lq_count=2 and lu_ready=0.
  - Pipes then idle -> both entries written in one cycle on ports 1 and 2.
- Kill: queue holds rd=4. Next cycle p1(rd=4,0x44) -> the queued value is never written; rd4 receives 0x44; lq_count returns to 0.
- Reset mid-operation: queue full, rst=0 for one edge -> no writes afterward, lq_count=0, lu_ready=1.
